// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and helpers for the RV32E front end.
// Optional FETCH_PERF_EN adds a fetch-starvation cycle counter on fetch_unit.
package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH_RUN,
    FETCH_HALT
  } fetch_state;

  localparam int INSTRUCTION_BYTES = 4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Valid/ready link carrying raw instruction words from fetch to decode.
// downstream is the producer view, upstream the consumer view.
interface skid_buffer_port #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport downstream (
    output valid,
    output data,
    input  ready
  );

  modport upstream (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// In-order return buffer for fetched words; flush beats push and pop.
// Power-of-two depth so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic             w_wen;

  assign w_wen = push && !flush && !reset;

  always_ff @(posedge clock) begin
    if (w_wen) begin
      r_mem[r_wr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (pop) begin
        r_rd <= r_rd + 1'b1;
      end
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  assign head  = r_mem[r_rd];
  assign count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// RV32E fetch stage: PC, capped memory reads, return FIFO, redirect flush.
// Define FETCH_PERF_EN to add the perf_starve_cycles output.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  skid_buffer_port.downstream        to_decode,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [31:0]                mem_req_addr,
  input  logic                       mem_resp_valid,
  input  logic [31:0]                mem_resp_data,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]                perf_starve_cycles,
`endif
  output logic                       fault
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state    r_state;
  fetch_state    w_state_nxt;
  logic          r_fault;
  logic          w_fault_nxt;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_count;
  logic [31:0]   w_head;
  logic [CW:0]   w_inflight;
  logic          w_run;
  logic          w_redir;
  logic          w_fire;
  logic          w_push;
  logic          w_valid;
  logic          w_pop;

  assign w_run      = (r_state == FETCH_RUN) && !reset;
  assign w_redir    = redirect_valid && (r_state == FETCH_RUN);
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_count};

  assign mem_req_valid = w_run && !redirect_valid &&
                         (w_inflight < (CW + 1)'(FIFO_DEPTH));
  assign mem_req_addr  = r_pc;
  assign w_fire        = mem_req_valid && mem_req_ready;

  // Words still owed to a flushed path never reach the FIFO.
  assign w_push = mem_resp_valid && (r_drop == '0) && w_run &&
                  !redirect_valid;

  assign w_valid = w_run && !redirect_valid && (w_count != '0);
  assign w_pop   = w_valid && to_decode.ready;

  assign to_decode.valid = w_valid;
  assign to_decode.data  = w_head;
  assign fault           = r_fault;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (mem_resp_data),
    .pop       (w_pop),
    .flush     (w_redir),
    .head      (w_head),
    .count     (w_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FETCH_RUN;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fault_nxt = r_fault;
    unique case (r_state)
      FETCH_RUN: begin
        if (redirect_valid && !is_word_aligned(redirect_pc)) begin
          w_state_nxt = FETCH_HALT;
          w_fault_nxt = 1'b1;
        end
      end
      FETCH_HALT: begin
        w_state_nxt = FETCH_HALT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc          <= RESET_VECTOR;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_fire) -
                       CW'(mem_resp_valid);
      if (w_redir) begin
        r_pc   <= redirect_pc;
        r_drop <= r_outstanding - CW'(mem_resp_valid);
      end else begin
        if (w_fire) begin
          r_pc <= r_pc + 32'(INSTRUCTION_BYTES);
        end
        if (mem_resp_valid && (r_drop != '0)) begin
          r_drop <= r_drop - 1'b1;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf <= '0;
    end else if ((r_state == FETCH_RUN) && (w_count == '0) &&
                 (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_starve_cycles = r_perf;
`endif

endmodule
